// File: rtl/dom_sbox_sequencer_pkg.sv
// Shared constants and types for the DOM S-box issue controller.
// Package name is dom_seq_pkg; it is imported by the interface, the FIFO and the top.
package dom_seq_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned DFLT_SHARES = 2;
  localparam int unsigned DFLT_TAG_W  = 4;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int unsigned credit_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // {tag, data} word stored in the output FIFO for the default configuration.
  typedef struct packed {
    logic [DFLT_TAG_W-1:0]         tag;
    logic [BYTE_W*DFLT_SHARES-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/dom_sbox_sequencer_if.sv
// Handshake and S-box datapath bundle of dom_sbox_sequencer.
// slave: the sequencer side; master: requester / S-box / consumer side.
interface dom_sbox_sequencer_if
  import dom_seq_pkg::*;
#(
  parameter int unsigned SHARES      = 2,
  parameter int unsigned N_STAGES    = 4,
  parameter int unsigned STAGE_RND_W = 8,
  parameter int unsigned TAG_W       = 4
);

  localparam int unsigned DATA_W = BYTE_W * SHARES;
  localparam int unsigned RND_W  = N_STAGES * STAGE_RND_W;

  logic              InValidxSI;
  logic              InReadyxSO;
  logic [DATA_W-1:0] InDataxDI;
  logic [TAG_W-1:0]  InTagxDI;
  logic              RndValidxSI;
  logic              RndReadyxSO;
  logic [RND_W-1:0]  RndxDI;
  logic [DATA_W-1:0] SboxInxDO;
  logic [RND_W-1:0]  SboxRndxDO;
  logic [DATA_W-1:0] SboxOutxDI;
  logic              OutValidxSO;
  logic              OutReadyxSI;
  logic [DATA_W-1:0] OutDataxDO;
  logic [TAG_W-1:0]  OutTagxDO;

  modport slave (
    input  InValidxSI, InDataxDI, InTagxDI, RndValidxSI, RndxDI, SboxOutxDI, OutReadyxSI,
    output InReadyxSO, RndReadyxSO, SboxInxDO, SboxRndxDO, OutValidxSO, OutDataxDO, OutTagxDO
  );

  modport master (
    output InValidxSI, InDataxDI, InTagxDI, RndValidxSI, RndxDI, SboxOutxDI, OutReadyxSI,
    input  InReadyxSO, RndReadyxSO, SboxInxDO, SboxRndxDO, OutValidxSO, OutDataxDO, OutTagxDO
  );

endinterface

// File: rtl/dom_sbox_sequencer_fifo.sv
// dom_seq_fifo: synchronous first-word-fall-through FIFO with flush.
// Optional macro DOM_SEQ_CLEAR_IDLE_EN: zero the storage word on pop.
module dom_seq_fifo
  import dom_seq_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  // Status flags and read port; extra pointer bit distinguishes full from empty.
  always_comb begin
    empty_o = (wr_ptr_q == rd_ptr_q);
    full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer and storage update; a write to the slot being popped wins.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_pop) begin
`ifdef DOM_SEQ_CLEAR_IDLE_EN
        mem_d[rd_ptr_q[AW-1:0]] = '0;
`endif
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/dom_sbox_sequencer.sv
// Issue controller for a fixed-latency pipelined DOM masked AES S-box.
// Optional macro DOM_SEQ_CLEAR_IDLE_EN: drive idle S-box inputs and randomness
// slices to zero instead of holding the last value.
module dom_sbox_sequencer
  import dom_seq_pkg::*;
#(
  parameter int unsigned SHARES      = 2,
  parameter int unsigned N_STAGES    = 4,
  parameter int unsigned STAGE_RND_W = 8,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned OUT_DEPTH   = 4
) (
  input  logic                    ClkxCI,
  input  logic                    RstxBI,
  input  logic                    FlushxSI,
  dom_sbox_sequencer_if.slave     bus,
  output logic                    BusyxSO
);

  localparam int unsigned DATA_W = BYTE_W * SHARES;
  localparam int unsigned CW     = credit_w(OUT_DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              credit_ok, issue, pop, cap;
  logic [CW-1:0]     credit_q, credit_d;
  logic [N_STAGES:0] vld_q, vld_d;
  logic [TAG_W-1:0]  tag_q [N_STAGES+1];
  logic [TAG_W-1:0]  tag_d [N_STAGES+1];
  logic [DATA_W-1:0] sbox_in_q, sbox_in_d;
  entry_t            fifo_wdata, fifo_rdata;
  logic              fifo_full, fifo_empty;

  // Handshakes: both sides complete together; nothing completes in reset or flush.
  always_comb begin
    credit_ok       = (credit_q != '0);
    bus.InReadyxSO  = RstxBI && bus.RndValidxSI && credit_ok && !FlushxSI;
    bus.RndReadyxSO = RstxBI && bus.InValidxSI && credit_ok && !FlushxSI;
    issue           = bus.InReadyxSO && bus.InValidxSI;
    bus.OutValidxSO = RstxBI && !fifo_empty && !FlushxSI;
    pop             = bus.OutValidxSO && bus.OutReadyxSI;
    cap             = vld_q[N_STAGES] && !FlushxSI;
  end

  // Credits track free FIFO slots minus tokens already in flight.
  always_comb begin
    credit_d = credit_q;
    if (FlushxSI)
      credit_d = CW'(OUT_DEPTH);
    else if (issue && !pop)
      credit_d = credit_q - CW'(1);
    else if (pop && !issue)
      credit_d = credit_q + CW'(1);
  end

  // Token valid/tag shift register and registered S-box data input.
  always_comb begin
    vld_d     = FlushxSI ? '0 : {vld_q[N_STAGES-1:0], issue};
    tag_d[0]  = bus.InTagxDI;
    for (int unsigned j = 1; j <= N_STAGES; j++)
      tag_d[j] = tag_q[j-1];
    sbox_in_d = issue ? bus.InDataxDI : sbox_in_q;
  end

  // Pipeline tracking state.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      credit_q  <= CW'(OUT_DEPTH);
      vld_q     <= '0;
      tag_q     <= '{default: '0};
      sbox_in_q <= '0;
    end else begin
      credit_q  <= credit_d;
      vld_q     <= vld_d;
      tag_q     <= tag_d;
      sbox_in_q <= sbox_in_d;
    end
  end

`ifdef DOM_SEQ_CLEAR_IDLE_EN
  assign bus.SboxInxDO = vld_q[0] ? sbox_in_q : '0;
`else
  assign bus.SboxInxDO = sbox_in_q;
`endif

  // Per-stage randomness delay lines: slice k travels k extra registers and
  // only advances behind a live token, so an idle stage keeps its last slice.
  for (genvar k = 0; k < N_STAGES; k++) begin : g_rnd
    localparam int unsigned K = k;
    logic [STAGE_RND_W-1:0] line_q [K+1];
    logic [STAGE_RND_W-1:0] line_d [K+1];

    // Load on issue, then follow the token down the pipe.
    always_comb begin
      line_d = line_q;
      if (issue)
        line_d[0] = bus.RndxDI[K*STAGE_RND_W +: STAGE_RND_W];
      for (int unsigned j = 1; j <= K; j++)
        if (vld_q[j-1] && !FlushxSI)
          line_d[j] = line_q[j-1];
    end

    // Delay-line registers.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI)
        line_q <= '{default: '0};
      else
        line_q <= line_d;
    end

`ifdef DOM_SEQ_CLEAR_IDLE_EN
    assign bus.SboxRndxDO[K*STAGE_RND_W +: STAGE_RND_W] = vld_q[K] ? line_q[K] : '0;
`else
    assign bus.SboxRndxDO[K*STAGE_RND_W +: STAGE_RND_W] = line_q[K];
`endif
  end

  // Result capture: the S-box output is sampled in the cycle the token leaves the pipe.
  always_comb begin
    fifo_wdata.tag  = tag_q[N_STAGES];
    fifo_wdata.data = bus.SboxOutxDI;
  end

  dom_seq_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk     (ClkxCI),
    .rst_n   (RstxBI),
    .flush_i (FlushxSI),
    .push_i  (cap && !fifo_full),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.OutDataxDO = fifo_rdata.data;
  assign bus.OutTagxDO  = fifo_rdata.tag;
  assign BusyxSO        = (|vld_q) || !fifo_empty;

endmodule

// File: tb/tb_dom_sbox_sequencer.sv
// Directed self-checking bench for dom_sbox_sequencer (depth-4 and depth-8 instances).
module tb_dom_sbox_sequencer;
  import dom_seq_pkg::*;

`ifdef DOM_SEQ_CLEAR_IDLE_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush4, flush8, busy4, busy8;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  dom_sbox_sequencer_if #(.SHARES(2), .N_STAGES(4), .STAGE_RND_W(8), .TAG_W(4)) bus4 ();
  dom_sbox_sequencer_if #(.SHARES(2), .N_STAGES(4), .STAGE_RND_W(8), .TAG_W(4)) bus8 ();

  dom_sbox_sequencer #(.SHARES(2), .N_STAGES(4), .STAGE_RND_W(8), .TAG_W(4), .OUT_DEPTH(4)) dut (
    .ClkxCI(clk), .RstxBI(rst_n), .FlushxSI(flush4), .bus(bus4.slave), .BusyxSO(busy4));
  dom_sbox_sequencer #(.SHARES(2), .N_STAGES(4), .STAGE_RND_W(8), .TAG_W(4), .OUT_DEPTH(8)) dut8 (
    .ClkxCI(clk), .RstxBI(rst_n), .FlushxSI(flush8), .bus(bus8.slave), .BusyxSO(busy8));

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic idle4();
    bus4.InValidxSI = 0; bus4.RndValidxSI = 0; bus4.InDataxDI = '0; bus4.InTagxDI = '0;
    bus4.RndxDI = '0; bus4.SboxOutxDI = '0; bus4.OutReadyxSI = 1;
  endtask

  task automatic test_reset();
    idle4();
    bus8.InValidxSI = 0; bus8.RndValidxSI = 0; bus8.InDataxDI = '0; bus8.InTagxDI = '0;
    bus8.RndxDI = '0; bus8.SboxOutxDI = '0; bus8.OutReadyxSI = 1;
    flush4 = 0; flush8 = 0; rst_n = 0;
    bus4.InValidxSI = 1; bus4.RndValidxSI = 1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({bus4.InReadyxSO, bus4.RndReadyxSO, bus4.OutValidxSO, busy4} !== 4'b0) begin
      n_fail++; $display("FAIL reset_handshake: got %b expected 0000",
                         {bus4.InReadyxSO, bus4.RndReadyxSO, bus4.OutValidxSO, busy4});
    end
    bus4.InValidxSI = 0; bus4.RndValidxSI = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk); #1;
    n_checks++;
    if ({bus4.SboxInxDO, bus4.SboxRndxDO, bus4.OutDataxDO, bus4.OutTagxDO} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h/%h/%h/%h expected all zero",
                         bus4.SboxInxDO, bus4.SboxRndxDO, bus4.OutDataxDO, bus4.OutTagxDO);
    end
    n_checks++;
    if (dut.credit_q !== 3'd4) begin
      n_fail++; $display("FAIL reset_credit: got %0d expected 4", dut.credit_q);
    end
  endtask

  // Token 0x3A5C / tag 7 / rnd 0x44332211 issued from an all-zero (post-reset) state.
  task automatic test_single(input string nm);
    logic [31:0] hold_tab  [4] = '{32'h00000011, 32'h00002211, 32'h00332211, 32'h44332211};
    logic [31:0] clear_tab [4] = '{32'h00000011, 32'h00002200, 32'h00330000, 32'h44000000};
    fifo_entry_t exp;
    @(negedge clk);
    idle4();
    bus4.InDataxDI = 16'h3A5C; bus4.InTagxDI = 4'h7; bus4.RndxDI = 32'h44332211;
    bus4.InValidxSI = 1; bus4.RndValidxSI = 1;
    #1;
    n_checks++;
    if ({bus4.InReadyxSO, bus4.RndReadyxSO} !== 2'b11) begin
      n_fail++; $display("FAIL %s_ready: got %b expected 11", nm, {bus4.InReadyxSO, bus4.RndReadyxSO});
    end
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      bus4.InValidxSI = 0; bus4.RndValidxSI = 0;
      bus4.SboxOutxDI = (c == 5) ? 16'hBEEF : 16'h0F0F;
      #1;
      if (c <= 4) begin
        n_checks++;
        if (bus4.SboxRndxDO !== (CLEAR ? clear_tab[c-1] : hold_tab[c-1])) begin
          n_fail++; $display("FAIL %s_rnd_c%0d: got %h expected %h", nm, c, bus4.SboxRndxDO,
                             CLEAR ? clear_tab[c-1] : hold_tab[c-1]);
        end
        n_checks++;
        if (bus4.SboxInxDO !== ((c == 1 || !CLEAR) ? 16'h3A5C : 16'h0000)) begin
          n_fail++; $display("FAIL %s_sbox_in_c%0d: got %h expected %h", nm, c, bus4.SboxInxDO,
                             (c == 1 || !CLEAR) ? 16'h3A5C : 16'h0000);
        end
      end
      if (c == 5 || c == 7) begin
        n_checks++;
        if (bus4.OutValidxSO !== 1'b0) begin
          n_fail++; $display("FAIL %s_outvalid_c%0d: got %b expected 0", nm, c, bus4.OutValidxSO);
        end
      end
      if (c == 6) begin
        exp.tag = 4'h7; exp.data = 16'hBEEF;
        n_checks++;
        if ({bus4.OutValidxSO, bus4.OutTagxDO, bus4.OutDataxDO} !== {1'b1, exp}) begin
          n_fail++; $display("FAIL %s_result: got %b/%h/%h expected 1/7/beef", nm,
                             bus4.OutValidxSO, bus4.OutTagxDO, bus4.OutDataxDO);
        end
      end
    end
    n_checks++;
    if (busy4 !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_end: got %b expected 0", nm, busy4);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned got = 0;
    int unsigned first_n = 0;
    fifo_entry_t exp;
    for (int n = 0; n < 22; n++) begin
      @(negedge clk);
      bus8.InValidxSI = (n < 10); bus8.RndValidxSI = (n < 10);
      bus8.InTagxDI = 4'(n); bus8.InDataxDI = 16'(n); bus8.RndxDI = {4{8'(n)}};
      bus8.SboxOutxDI = 16'(32'h1000 + n); bus8.OutReadyxSI = 1;
      #1;
      if (n < 10) begin
        n_checks++;
        if (bus8.InReadyxSO !== 1'b1) begin
          n_fail++; $display("FAIL b2b_inready_%0d: got %b expected 1", n, bus8.InReadyxSO);
        end
      end
      if (bus8.OutValidxSO === 1'b1) begin
        if (got == 0) first_n = n;
        exp.tag = 4'(got); exp.data = 16'(32'h1005 + got);
        n_checks++;
        if ({bus8.OutTagxDO, bus8.OutDataxDO} !== exp) begin
          n_fail++; $display("FAIL b2b_result_%0d: got %h/%h expected %h/%h", got,
                             bus8.OutTagxDO, bus8.OutDataxDO, exp.tag, exp.data);
        end
        got++;
      end
    end
    n_checks++;
    if (got != 10 || first_n != 6) begin
      n_fail++; $display("FAIL b2b_count: got %0d results first at %0d expected 10 first at 6", got, first_n);
    end
  endtask

  task automatic flush_pulse();
    @(negedge clk); idle4(); flush4 = 1;
    @(negedge clk); flush4 = 0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int unsigned acc = 0;
    int unsigned acc2 = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      bus4.OutReadyxSI = 0; bus4.InValidxSI = 1; bus4.RndValidxSI = 1;
      bus4.InTagxDI = 4'(acc); bus4.InDataxDI = 16'(32'hA000 + acc);
      bus4.SboxOutxDI = 16'(32'hB000 + n);
      #1;
      if (bus4.InReadyxSO === 1'b1) acc++;
    end
    n_checks++;
    if (acc != 4 || bus4.InReadyxSO !== 1'b0 || dut.credit_q !== 3'd0) begin
      n_fail++; $display("FAIL bp_stall: got acc=%0d ready=%b credit=%0d expected 4/0/0",
                         acc, bus4.InReadyxSO, dut.credit_q);
    end
    n_checks++;
    if ({bus4.OutValidxSO, bus4.OutTagxDO, bus4.OutDataxDO} !== {1'b1, 4'h0, 16'hB005}) begin
      n_fail++; $display("FAIL bp_head0: got %b/%h/%h expected 1/0/b005",
                         bus4.OutValidxSO, bus4.OutTagxDO, bus4.OutDataxDO);
    end
    @(negedge clk); bus4.OutReadyxSI = 1; #1;
    n_checks++;
    if (bus4.InReadyxSO !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready_during_pop: got %b expected 0", bus4.InReadyxSO);
    end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk); bus4.OutReadyxSI = 0; bus4.InTagxDI = 4'h4; #1;
      if (bus4.InReadyxSO === 1'b1) acc2++;
    end
    n_checks++;
    if (acc2 != 1 || dut.credit_q !== 3'd0) begin
      n_fail++; $display("FAIL bp_one_more: got acc=%0d credit=%0d expected 1/0", acc2, dut.credit_q);
    end
    n_checks++;
    if ({bus4.OutTagxDO, bus4.OutDataxDO} !== {4'h1, 16'hB006}) begin
      n_fail++; $display("FAIL bp_head1: got %h/%h expected 1/b006", bus4.OutTagxDO, bus4.OutDataxDO);
    end
    flush_pulse();
  endtask

  task automatic test_starvation();
    @(negedge clk); idle4();
    bus4.InDataxDI = 16'h1234; bus4.InTagxDI = 4'h2; bus4.RndxDI = 32'h88776655;
    bus4.InValidxSI = 1; bus4.RndValidxSI = 1;
    @(negedge clk); idle4();
    repeat (8) @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      bus4.InValidxSI = 1; bus4.RndValidxSI = 0; bus4.InDataxDI = 16'h5678;
      bus4.InTagxDI = 4'h3; bus4.RndxDI = 32'hDDCCBBAA;
      #1;
      n_checks++;
      if ({bus4.InReadyxSO, bus4.RndReadyxSO, busy4} !== 3'b010) begin
        n_fail++; $display("FAIL starve_hs_%0d: got %b expected 010", n,
                           {bus4.InReadyxSO, bus4.RndReadyxSO, busy4});
      end
      n_checks++;
      if ({bus4.SboxInxDO, bus4.SboxRndxDO} !== (CLEAR ? 48'h0 : {16'h1234, 32'h88776655})) begin
        n_fail++; $display("FAIL starve_hold_%0d: got %h/%h expected %h", n, bus4.SboxInxDO,
                           bus4.SboxRndxDO, CLEAR ? 48'h0 : {16'h1234, 32'h88776655});
      end
    end
    @(negedge clk); bus4.RndValidxSI = 1; #1;
    n_checks++;
    if (bus4.InReadyxSO !== 1'b1) begin
      n_fail++; $display("FAIL starve_resume: got %b expected 1", bus4.InReadyxSO);
    end
    @(negedge clk); idle4(); #1;
    n_checks++;
    if ({bus4.SboxInxDO, bus4.SboxRndxDO} !== {16'h5678, CLEAR ? 32'h000000AA : 32'h887766AA}) begin
      n_fail++; $display("FAIL starve_issue: got %h/%h expected 5678/%h", bus4.SboxInxDO,
                         bus4.SboxRndxDO, CLEAR ? 32'h000000AA : 32'h887766AA);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_flush();
    logic seen_valid = 1'b0;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      bus4.OutReadyxSI = 0; bus4.InValidxSI = (n < 5); bus4.RndValidxSI = (n < 5);
      bus4.InTagxDI = 4'(n + 8); bus4.InDataxDI = 16'(n);
      bus4.SboxOutxDI = 16'(32'hC000 + n);
    end
    #1;
    n_checks++;
    if ({bus4.OutValidxSO, busy4, bus4.OutTagxDO} !== {2'b11, 4'h8}) begin
      n_fail++; $display("FAIL flush_pre: got %b%b/%h expected 11/8", bus4.OutValidxSO, busy4, bus4.OutTagxDO);
    end
    @(negedge clk);
    flush4 = 1; bus4.InValidxSI = 1; bus4.RndValidxSI = 1; bus4.SboxOutxDI = 16'hC007;
    #1;
    n_checks++;
    if ({bus4.InReadyxSO, bus4.RndReadyxSO, bus4.OutValidxSO} !== 3'b000) begin
      n_fail++; $display("FAIL flush_block: got %b expected 000",
                         {bus4.InReadyxSO, bus4.RndReadyxSO, bus4.OutValidxSO});
    end
    @(negedge clk); flush4 = 0; idle4(); #1;
    n_checks++;
    if ({bus4.OutValidxSO, busy4} !== 2'b00 || dut.credit_q !== 3'd4) begin
      n_fail++; $display("FAIL flush_after: got valid/busy %b%b credit %0d expected 00/4",
                         bus4.OutValidxSO, busy4, dut.credit_q);
    end
    for (int n = 0; n < 7; n++) begin
      @(negedge clk); bus4.SboxOutxDI = 16'(32'hD000 + n); #1;
      if (bus4.OutValidxSO !== 1'b0 || busy4 !== 1'b0) seen_valid = 1'b1;
    end
    n_checks++;
    if (seen_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_no_capture: got %b expected 0", seen_valid);
    end
  endtask

  task automatic test_async_reset();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      bus4.OutReadyxSI = 1; bus4.InValidxSI = 1; bus4.RndValidxSI = 1;
      bus4.InTagxDI = 4'(n); bus4.InDataxDI = 16'hFF00 | 16'(n); bus4.RndxDI = 32'hCAFEF00D;
      bus4.SboxOutxDI = 16'h7777;
    end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({bus4.SboxInxDO, bus4.SboxRndxDO, bus4.OutDataxDO, bus4.OutTagxDO} !== '0 ||
        {bus4.InReadyxSO, bus4.RndReadyxSO, bus4.OutValidxSO, busy4} !== 4'b0) begin
      n_fail++; $display("FAIL areset_outputs: got %h/%h/%h/%h %b expected all zero",
                         bus4.SboxInxDO, bus4.SboxRndxDO, bus4.OutDataxDO, bus4.OutTagxDO,
                         {bus4.InReadyxSO, bus4.RndReadyxSO, bus4.OutValidxSO, busy4});
    end
    @(negedge clk); idle4();
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    test_single("areset_single");
  endtask

  initial begin
    test_reset();
    test_single("single");
    test_back_to_back();
    test_backpressure();
    test_starvation();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
